mem_port_arbiter: RTL and testbench

- Shares one single-ported unified memory between the pipeline's instruction-fetch port (IF) and data-memory port (MEM stage loads/stores).
- Grants one transaction at a time and routes the response back to its owner.
- Drives per-port grant/valid so the hazard logic can stall IF or MEM while the other port owns the memory.
- Default policy: data requests win ties, because the MEM-stage instruction is older.

---
 rtl/mem_port_arbiter.sv | 117 +++++++++++
 tb/tb_mem_port_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - IF/MEM arbiter for one single-ported unified memory
// Optional feature macro: ARB_STARVE_GUARD_EN (bounds IF starvation by data grants)
module mem_port_arbiter #(
    parameter int XLEN       = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [XLEN-1:0] if_rdata,
    input  logic            dm_req,
    input  logic            dm_we,
    input  logic [XLEN-1:0] dm_addr,
    input  logic [XLEN-1:0] dm_wdata,
    output logic            dm_gnt,
    output logic            dm_rvalid,
    output logic [XLEN-1:0] dm_rdata,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_ready,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_BUSY_IF = 2'd1;
    localparam logic [1:0] ST_BUSY_DM = 2'd2;

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic       w_idle;
    logic       w_force_if;
    logic       w_sel_dm;
    logic       w_sel_if;
    logic       w_if_resp;
    logic       w_dm_resp;

    assign w_idle = (r_state == ST_IDLE);

`ifdef ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] r_starve_cnt;

    assign w_force_if = if_req && (r_starve_cnt == CNT_W'(STARVE_MAX));

    // Count data grants taken while IF waits; an IF grant clears the count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_starve_cnt <= '0;
        end else if (if_gnt) begin
            r_starve_cnt <= '0;
        end else if (dm_gnt && if_req && (r_starve_cnt != CNT_W'(STARVE_MAX))) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end
`else
    // Strict data priority: IF is never forced ahead of a data request
    assign w_force_if = (STARVE_MAX < 0);
`endif

    // Data wins ties because the MEM-stage instruction is older
    assign w_sel_dm = dm_req && !w_force_if;
    assign w_sel_if = if_req && !w_sel_dm;

    assign mem_req   = w_idle && (w_sel_dm || w_sel_if);
    assign mem_we    = w_idle && w_sel_dm && dm_we;
    assign mem_addr  = !w_idle ? '0 : (w_sel_dm ? dm_addr : (w_sel_if ? if_addr : '0));
    assign mem_wdata = (w_idle && w_sel_dm) ? dm_wdata : '0;

    assign if_gnt = w_idle && w_sel_if && mem_ready;
    assign dm_gnt = w_idle && w_sel_dm && mem_ready;

    // Responses in IDLE are stale and never reach either port
    assign w_if_resp = (r_state == ST_BUSY_IF) && mem_rvalid;
    assign w_dm_resp = (r_state == ST_BUSY_DM) && mem_rvalid;

    assign if_rvalid = w_if_resp;
    assign dm_rvalid = w_dm_resp;
    assign if_rdata  = w_if_resp ? mem_rdata : '0;
    assign dm_rdata  = w_dm_resp ? mem_rdata : '0;

    // Next state: grant moves to the owner's BUSY state, response returns to IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (dm_gnt) begin
                    w_state_nxt = ST_BUSY_DM;
                end else if (if_gnt) begin
                    w_state_nxt = ST_BUSY_IF;
                end
            end
            ST_BUSY_IF, ST_BUSY_DM: begin
                if (mem_rvalid) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register; reset abandons any outstanding transaction
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_gnt;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;
    int n_if_gnt;
    int n_dm_gnt;
    int n_gnt;
    int first_if_idx;

    mem_port_arbiter #(.XLEN(32), .STARVE_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        if_req = 0; if_addr = 0;
        dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0;
        mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_if_gnt"}, {31'd0, if_gnt}, 0);
        chk({tag, "_if_rvalid"}, {31'd0, if_rvalid}, 0);
        chk({tag, "_if_rdata"}, if_rdata, 0);
        chk({tag, "_dm_gnt"}, {31'd0, dm_gnt}, 0);
        chk({tag, "_dm_rvalid"}, {31'd0, dm_rvalid}, 0);
        chk({tag, "_dm_rdata"}, dm_rdata, 0);
        chk({tag, "_mem_req"}, {31'd0, mem_req}, 0);
        chk({tag, "_mem_we"}, {31'd0, mem_we}, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
    endtask

    initial begin
        // Reset with no requests
        reset = 1;
        clear_inputs();
        #2;
        chk_all_zero("rst");
        tick(); tick();
        reset = 0;
        #1;
        chk_all_zero("post_rst");
        tick();

        // Fetch only, memory answers two cycles after grant
        if_req = 1; if_addr = 32'h100; mem_ready = 1;
        #1;
        chk("f_if_gnt", {31'd0, if_gnt}, 1);
        chk("f_mem_req", {31'd0, mem_req}, 1);
        chk("f_mem_addr", mem_addr, 32'h100);
        chk("f_mem_we", {31'd0, mem_we}, 0);
        chk("f_dm_gnt", {31'd0, dm_gnt}, 0);
        tick();
        if_req = 0; mem_ready = 0;
        #1;
        chk("f_c1_rvalid", {31'd0, if_rvalid}, 0);
        chk("f_c1_mem_req", {31'd0, mem_req}, 0);
        tick();
        mem_rvalid = 1; mem_rdata = 32'h00500093;
        #1;
        chk("f_if_rvalid", {31'd0, if_rvalid}, 1);
        chk("f_if_rdata", if_rdata, 32'h00500093);
        chk("f_dm_rvalid", {31'd0, dm_rvalid}, 0);
        chk("f_dm_rdata", dm_rdata, 0);
        tick();
        clear_inputs();
        tick();

        // Tie: data wins, fetch follows in the next idle cycle
        if_req = 1; if_addr = 32'h104;
        dm_req = 1; dm_we = 0; dm_addr = 32'h2000; mem_ready = 1;
        #1;
        chk("t_dm_gnt", {31'd0, dm_gnt}, 1);
        chk("t_if_gnt0", {31'd0, if_gnt}, 0);
        chk("t_mem_addr0", mem_addr, 32'h2000);
        chk("t_mem_we0", {31'd0, mem_we}, 0);
        tick();
        dm_req = 0; mem_rvalid = 1; mem_rdata = 32'h11112222;
        #1;
        chk("t_dm_rvalid", {31'd0, dm_rvalid}, 1);
        chk("t_dm_rdata", dm_rdata, 32'h11112222);
        chk("t_if_rvalid1", {31'd0, if_rvalid}, 0);
        chk("t_if_rdata1", if_rdata, 0);
        chk("t_if_gnt1", {31'd0, if_gnt}, 0);
        chk("t_mem_req1", {31'd0, mem_req}, 0);
        tick();
        mem_rvalid = 0;
        #1;
        chk("t_if_gnt2", {31'd0, if_gnt}, 1);
        chk("t_mem_addr2", mem_addr, 32'h104);
        tick();
        if_req = 0; mem_rvalid = 1; mem_rdata = 32'h33334444;
        #1;
        chk("t_if_rvalid3", {31'd0, if_rvalid}, 1);
        chk("t_if_rdata3", if_rdata, 32'h33334444);
        chk("t_dm_rvalid3", {31'd0, dm_rvalid}, 0);
        tick();
        clear_inputs();
        tick();

        // Back-pressured store
        dm_req = 1; dm_we = 1; dm_addr = 32'h2004; dm_wdata = 32'hDEADBEEF; mem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_mem_req", {31'd0, mem_req}, 1);
            chk("bp_mem_we", {31'd0, mem_we}, 1);
            chk("bp_mem_addr", mem_addr, 32'h2004);
            chk("bp_mem_wdata", mem_wdata, 32'hDEADBEEF);
            chk("bp_dm_gnt", {31'd0, dm_gnt}, 0);
            tick();
        end
        mem_ready = 1;
        #1;
        chk("bp_dm_gnt3", {31'd0, dm_gnt}, 1);
        tick();
        dm_req = 0; dm_we = 0; mem_ready = 0; mem_rvalid = 1; mem_rdata = 0;
        #1;
        chk("bp_dm_ack", {31'd0, dm_rvalid}, 1);
        chk("bp_if_rvalid", {31'd0, if_rvalid}, 0);
        tick();
        clear_inputs();
        tick();

        // Starvation: both ports request continuously, memory answers next cycle
        if_req = 1; if_addr = 32'h300;
        dm_req = 1; dm_we = 0; dm_addr = 32'h4000;
        mem_ready = 1; mem_rvalid = 1; mem_rdata = 32'h5;
        n_if_gnt = 0; n_dm_gnt = 0; n_gnt = 0; first_if_idx = -1;
        for (int c = 0; c < 50; c++) begin
            #1;
            if (if_gnt && first_if_idx < 0) first_if_idx = n_gnt;
            if (if_gnt) n_if_gnt++;
            if (dm_gnt) n_dm_gnt++;
            if (if_gnt || dm_gnt) n_gnt++;
            tick();
        end
`ifdef ARB_STARVE_GUARD_EN
        chk("sv_if_gnts", n_if_gnt, 5);
        chk("sv_dm_gnts", n_dm_gnt, 20);
        chk("sv_first_if", first_if_idx, 4);
`else
        chk("sv_if_gnts", n_if_gnt, 0);
        chk("sv_dm_gnts", n_dm_gnt, 25);
`endif
        clear_inputs();
        tick();

        // Reset while data transaction is outstanding, then a late response
        dm_req = 1; dm_we = 0; dm_addr = 32'h3000; mem_ready = 1;
        #1;
        chk("r6_dm_gnt", {31'd0, dm_gnt}, 1);
        tick();
        dm_req = 0; mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'hAAAA5555;
        #1;
        chk("r6_busy_rvalid", {31'd0, dm_rvalid}, 1);
        #1;
        reset = 1;
        #1;
        chk("r6_async_rvalid", {31'd0, dm_rvalid}, 0);
        chk("r6_async_rdata", dm_rdata, 0);
        mem_rvalid = 0;
        tick(); tick();
        reset = 0;
        tick();
        mem_rvalid = 1;
        #1;
        chk("r6_stale_dm", {31'd0, dm_rvalid}, 0);
        chk("r6_stale_if", {31'd0, if_rvalid}, 0);
        chk("r6_stale_rdata", dm_rdata, 0);
        tick();
        mem_rvalid = 0; if_req = 1; if_addr = 32'h200; mem_ready = 1;
        #1;
        chk("r6_if_gnt", {31'd0, if_gnt}, 1);
        chk("r6_mem_addr", mem_addr, 32'h200);
        tick();
        if_req = 0; mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'h01234567;
        #1;
        chk("r6_if_rvalid", {31'd0, if_rvalid}, 1);
        chk("r6_if_rdata", if_rdata, 32'h01234567);
        tick();
        clear_inputs();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
